// File: rtl/ex_cdb_arbiter.sv
// Common data bus arbiter: per-unit result FIFOs drained one entry per cycle
// onto a registered broadcast bus, round-robin across units.
module ex_cdb_arbiter #(
    parameter int                 UNIT_NUM    = 4,
    parameter int                 TAG_W       = 5,
    parameter int                 DATA_W      = 32,
    parameter int                 DEPTH       = 2,
    parameter logic [TAG_W-1:0]   TAG_INVALID = {TAG_W{1'b1}}
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_flush,
    input  logic [UNIT_NUM*TAG_W-1:0]     i_req_tag,
    input  logic [UNIT_NUM*DATA_W-1:0]    i_req_data,
    output logic [UNIT_NUM-1:0]           o_stall,
    output logic [TAG_W-1:0]              o_cdb_tag,
    output logic [DATA_W-1:0]             o_cdb_data,
    output logic [$clog2(UNIT_NUM)-1:0]   o_cdb_unit
);

    localparam int UNIT_W = $clog2(UNIT_NUM);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic [TAG_W-1:0]  r_tag_mem  [UNIT_NUM][DEPTH];
    logic [DATA_W-1:0] r_data_mem [UNIT_NUM][DEPTH];
    logic [PTR_W-1:0]  r_wptr     [UNIT_NUM];
    logic [PTR_W-1:0]  r_rptr     [UNIT_NUM];
    logic [CNT_W-1:0]  r_count    [UNIT_NUM];
    logic [UNIT_W-1:0] r_rr_ptr;

    logic [UNIT_NUM-1:0] w_full;
    logic [UNIT_NUM-1:0] w_nonempty;
    logic [UNIT_NUM-1:0] w_push;
    logic [UNIT_NUM-1:0] w_pop;
    logic                w_grant_valid;
    logic [UNIT_W-1:0]   w_grant;
    logic [UNIT_W-1:0]   w_idx;
    logic [TAG_W-1:0]    w_head_tag;
    logic [DATA_W-1:0]   w_head_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Stall comes from registered occupancy only, so a same-cycle pop never releases it.
    always_comb begin
        w_full     = '0;
        w_nonempty = '0;
        w_push     = '0;
        for (int u = 0; u < UNIT_NUM; u++) begin
            w_full[u]     = (r_count[u] == CNT_W'(DEPTH));
            w_nonempty[u] = (r_count[u] != '0);
            w_push[u]     = (i_req_tag[u*TAG_W +: TAG_W] != TAG_INVALID) && !w_full[u] && !i_flush;
        end
    end

    assign o_stall = w_full;

    // Scan from the highest offset down so the unit nearest r_rr_ptr wins.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant       = '0;
        w_idx         = '0;
        for (int i = UNIT_NUM - 1; i >= 0; i--) begin
            int idx;
            idx = int'(r_rr_ptr) + i;
            if (idx >= UNIT_NUM) idx = idx - UNIT_NUM;
            w_idx = UNIT_W'(idx);
            if (w_nonempty[w_idx]) begin
                w_grant_valid = 1'b1;
                w_grant       = w_idx;
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int u = 0; u < UNIT_NUM; u++) begin
            w_pop[u] = w_grant_valid && (w_grant == UNIT_W'(u));
        end
        w_head_tag  = r_tag_mem[w_grant][r_rptr[w_grant]];
        w_head_data = r_data_mem[w_grant][r_rptr[w_grant]];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int u = 0; u < UNIT_NUM; u++) begin
                r_wptr[u]  <= '0;
                r_rptr[u]  <= '0;
                r_count[u] <= '0;
            end
            r_rr_ptr   <= '0;
            o_cdb_tag  <= TAG_INVALID;
            o_cdb_data <= '0;
            o_cdb_unit <= '0;
        end else if (i_flush) begin
            for (int u = 0; u < UNIT_NUM; u++) begin
                r_wptr[u]  <= '0;
                r_rptr[u]  <= '0;
                r_count[u] <= '0;
            end
            r_rr_ptr  <= '0;
            o_cdb_tag <= TAG_INVALID;
        end else begin
            for (int u = 0; u < UNIT_NUM; u++) begin
                if (w_push[u]) begin
                    r_tag_mem[u][r_wptr[u]]  <= i_req_tag[u*TAG_W +: TAG_W];
                    r_data_mem[u][r_wptr[u]] <= i_req_data[u*DATA_W +: DATA_W];
                    r_wptr[u]                <= ptr_inc(r_wptr[u]);
                end
                if (w_pop[u]) r_rptr[u] <= ptr_inc(r_rptr[u]);
                if (w_push[u] && !w_pop[u]) begin
                    r_count[u] <= r_count[u] + 1'b1;
                end else if (!w_push[u] && w_pop[u]) begin
                    r_count[u] <= r_count[u] - 1'b1;
                end
            end
            if (w_grant_valid) begin
                o_cdb_tag  <= w_head_tag;
                o_cdb_data <= w_head_data;
                o_cdb_unit <= w_grant;
                r_rr_ptr   <= (int'(w_grant) == UNIT_NUM - 1) ? '0 : w_grant + 1'b1;
            end else begin
                o_cdb_tag <= TAG_INVALID;
            end
        end
    end

endmodule

// File: tb/tb_ex_cdb_arbiter.sv
// Bench for ex_cdb_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a queue-per-unit reference model.
module tb_ex_cdb_arbiter;

    localparam int UNIT_NUM = 4;
    localparam int TAG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int DEPTH    = 2;
    localparam int UNIT_W   = 2;
    localparam logic [TAG_W-1:0] TAG_INV = {TAG_W{1'b1}};

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic [TAG_W-1:0]  req_tag  [UNIT_NUM];
    logic [DATA_W-1:0] req_data [UNIT_NUM];
    logic [UNIT_NUM*TAG_W-1:0]  req_tag_bus;
    logic [UNIT_NUM*DATA_W-1:0] req_data_bus;
    logic [UNIT_NUM-1:0] stall;
    logic [TAG_W-1:0]    cdb_tag;
    logic [DATA_W-1:0]   cdb_data;
    logic [UNIT_W-1:0]   cdb_unit;

    always #5 clk = ~clk;

    always_comb begin
        for (int u = 0; u < UNIT_NUM; u++) begin
            req_tag_bus[u*TAG_W +: TAG_W]    = req_tag[u];
            req_data_bus[u*DATA_W +: DATA_W] = req_data[u];
        end
    end

    ex_cdb_arbiter #(
        .UNIT_NUM(UNIT_NUM), .TAG_W(TAG_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TAG_INVALID(TAG_INV)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_req_tag(req_tag_bus), .i_req_data(req_data_bus),
        .o_stall(stall), .o_cdb_tag(cdb_tag), .o_cdb_data(cdb_data), .o_cdb_unit(cdb_unit)
    );

    // Reference model: one queue of {tag,data} per unit, a round-robin start index,
    // and the expected broadcast registers.
    logic [TAG_W+DATA_W-1:0] exp_q [UNIT_NUM][$];
    int                  m_rr;
    logic [TAG_W-1:0]    m_tag;
    logic [DATA_W-1:0]   m_data;
    int                  m_unit;
    logic [UNIT_NUM-1:0] m_acc;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
        end
    endtask

    task automatic model_edge();
        logic [UNIT_NUM-1:0]     full;
        logic [TAG_W+DATA_W-1:0] e;
        int g;
        int u;
        if (rst) begin
            for (int k = 0; k < UNIT_NUM; k++) exp_q[k].delete();
            m_rr = 0; m_tag = TAG_INV; m_data = '0; m_unit = 0; m_acc = '0;
        end else if (flush) begin
            for (int k = 0; k < UNIT_NUM; k++) exp_q[k].delete();
            m_rr = 0; m_tag = TAG_INV; m_acc = '0;
        end else begin
            for (int k = 0; k < UNIT_NUM; k++) full[k] = (exp_q[k].size() == DEPTH);
            g = -1;
            for (int k = 0; k < UNIT_NUM; k++) begin
                u = (m_rr + k) % UNIT_NUM;
                if (g < 0 && exp_q[u].size() > 0) g = u;
            end
            if (g >= 0) begin
                e = exp_q[g].pop_front();
                m_tag  = e[TAG_W+DATA_W-1:DATA_W];
                m_data = e[DATA_W-1:0];
                m_unit = g;
                m_rr   = (g + 1) % UNIT_NUM;
            end else begin
                m_tag = TAG_INV;
            end
            for (int k = 0; k < UNIT_NUM; k++) begin
                m_acc[k] = (req_tag[k] != TAG_INV) && !full[k];
                if (m_acc[k]) exp_q[k].push_back({req_tag[k], req_data[k]});
            end
        end
    endtask

    task automatic check_outputs();
        logic [UNIT_NUM-1:0] exp_stall;
        for (int k = 0; k < UNIT_NUM; k++) exp_stall[k] = (exp_q[k].size() == DEPTH);
        check_eq("cdb_tag", 64'(cdb_tag), 64'(m_tag));
        check_eq("cdb_data", 64'(cdb_data), 64'(m_data));
        check_eq("cdb_unit", 64'(cdb_unit), 64'(m_unit));
        check_eq("stall", 64'(stall), 64'(exp_stall));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_reqs();
        for (int k = 0; k < UNIT_NUM; k++) begin
            req_tag[k]  = TAG_INV;
            req_data[k] = '0;
        end
    endtask

    task automatic set_req(input int u, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        req_tag[u]  = t;
        req_data[u] = d;
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        logic [TAG_W-1:0] got3 [$];
        logic             saw_stall3;
        int idx3;
        int alu_tag;
        int prev_unit;
        int next_tag;

        rst = 1'b1;
        flush = 1'b0;
        idle_reqs();
        @(negedge clk);
        tick();
        tick();
        check_eq("reset cdb_tag", 64'(cdb_tag), 64'(TAG_INV));
        check_eq("reset cdb_data", 64'(cdb_data), 64'd0);
        check_eq("reset stall", 64'(stall), 64'd0);
        rst = 1'b0;

        // Single request: visible one edge after the push edge, then idle again.
        set_req(0, 5'd3, 32'h11);
        tick();
        idle_reqs();
        check_eq("single no bypass", 64'(cdb_tag), 64'(TAG_INV));
        tick();
        check_eq("single tag", 64'(cdb_tag), 64'd3);
        check_eq("single data", 64'(cdb_data), 64'h11);
        check_eq("single unit", 64'(cdb_unit), 64'd0);
        tick();
        check_eq("single after", 64'(cdb_tag), 64'(TAG_INV));

        // Contention: four simultaneous pushes drain in unit order.
        flush_pulse();
        for (int u = 0; u < UNIT_NUM; u++) set_req(u, TAG_W'(u + 1), 32'h100 + 32'(u));
        tick();
        idle_reqs();
        for (int k = 0; k < UNIT_NUM; k++) begin
            tick();
            check_eq("contention order", 64'(cdb_tag), 64'(k + 1));
        end
        set_req(1, 5'd9, 32'h9);
        set_req(0, 5'd8, 32'h8);
        tick();
        idle_reqs();
        tick();
        check_eq("rr wrapped to 0", 64'(cdb_tag), 64'd8);
        tick();
        check_eq("rr second", 64'(cdb_tag), 64'd9);

        // Back-pressure: branch unit holds 5,6,7 while the ALU floods.
        flush_pulse();
        got3.delete();
        saw_stall3 = 1'b0;
        idx3 = 0;
        alu_tag = 10;
        set_req(3, 5'd5, 32'h55);
        set_req(0, TAG_W'(alu_tag), 32'(alu_tag));
        for (int c = 0; c < 20; c++) begin
            tick();
            saw_stall3 = saw_stall3 | stall[3];
            if (cdb_tag != TAG_INV && cdb_unit == 2'd3) got3.push_back(cdb_tag);
            if (m_acc[3]) begin
                idx3++;
                if (idx3 < 3) set_req(3, TAG_W'(5 + idx3), 32'(5 + idx3));
                else set_req(3, TAG_INV, '0);
            end
            if (m_acc[0]) begin
                alu_tag = (alu_tag >= 20) ? 10 : alu_tag + 1;
                if (c < 12) set_req(0, TAG_W'(alu_tag), 32'(alu_tag));
                else set_req(0, TAG_INV, '0);
            end
        end
        check_eq("bp stall seen", 64'(saw_stall3), 64'd1);
        check_eq("bp count", 64'(got3.size()), 64'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < got3.size()) check_eq("bp order", 64'(got3[k]), 64'(5 + k));
        end
        idle_reqs();

        // Fairness: ALU and forwarder continuously requesting alternate grants.
        flush_pulse();
        next_tag = 1;
        prev_unit = -1;
        set_req(0, TAG_W'(next_tag), 32'hA0);
        set_req(1, TAG_W'(next_tag + 1), 32'hB0);
        next_tag = 3;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (cdb_tag != TAG_INV) begin
                if (prev_unit >= 0) check_eq("fair alternate", 64'(int'(cdb_unit) != prev_unit), 64'd1);
                prev_unit = int'(cdb_unit);
            end
            for (int u = 0; u < 2; u++) begin
                if (m_acc[u]) begin
                    set_req(u, TAG_W'(next_tag), $urandom);
                    next_tag = (next_tag >= 30) ? 1 : next_tag + 1;
                end
            end
        end
        idle_reqs();

        // Flush with queued entries and a same-cycle push: nothing ever broadcast.
        flush_pulse();
        set_req(0, 5'd8, 32'h8);
        set_req(1, 5'd9, 32'h9);
        set_req(2, 5'd10, 32'hA);
        tick();
        idle_reqs();
        set_req(0, 5'd11, 32'hB);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle_reqs();
        check_eq("flush cdb_tag", 64'(cdb_tag), 64'(TAG_INV));
        check_eq("flush stall", 64'(stall), 64'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq("flush quiet", 64'(cdb_tag), 64'(TAG_INV));
        end

        // Reset mid-stream with full FIFOs and flush asserted together.
        for (int u = 0; u < UNIT_NUM; u++) set_req(u, TAG_W'(20 + u), 32'(u));
        for (int c = 0; c < 4; c++) tick();
        check_eq("prefill stall", 64'(stall != '0), 64'd1);
        rst = 1'b1;
        flush = 1'b1;
        tick();
        rst = 1'b0;
        flush = 1'b0;
        idle_reqs();
        check_eq("rst mid cdb_tag", 64'(cdb_tag), 64'(TAG_INV));
        check_eq("rst mid cdb_data", 64'(cdb_data), 64'd0);
        check_eq("rst mid cdb_unit", 64'(cdb_unit), 64'd0);
        check_eq("rst mid stall", 64'(stall), 64'd0);
        set_req(2, 5'd12, 32'hABC);
        tick();
        idle_reqs();
        tick();
        check_eq("post rst tag", 64'(cdb_tag), 64'd12);
        check_eq("post rst unit", 64'(cdb_unit), 64'd2);
        check_eq("post rst data", 64'(cdb_data), 64'hABC);

        // Random traffic; a unit keeps its request until the model accepts it.
        for (int c = 0; c < 3000; c++) begin
            for (int u = 0; u < UNIT_NUM; u++) begin
                if (req_tag[u] == TAG_INV || m_acc[u]) begin
                    if ($urandom_range(0, 99) < 60) set_req(u, TAG_W'($urandom_range(0, 30)), $urandom);
                    else set_req(u, TAG_INV, '0);
                end
            end
            flush = ($urandom_range(0, 39) == 0);
            rst   = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        flush = 1'b0;
        idle_reqs();
        for (int c = 0; c < 8; c++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
